regfile_sequencer: RTL and testbench



---
 rtl/regfile_sequencer.sv | 103 ++++++++++
 tb/tb_regfile_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Serialises operand reads and writebacks onto a 32x64 register file port set.
// Optional build macro REGSEQ_X0_GUARD_EN: x0 writes are dropped and x0 reads return zero.
module regfile_sequencer #(
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_rs1,
    input  logic [AW-1:0]   req_rs2,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [XLEN-1:0] op_rs1_data,
    output logic [XLEN-1:0] op_rs2_data,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            regWrite,
    output logic [AW-1:0]   readReg1,
    output logic [AW-1:0]   readReg2,
    output logic [AW-1:0]   writeReg,
    output logic [XLEN-1:0] writeData,
    input  logic [XLEN-1:0] readData1,
    input  logic [XLEN-1:0] readData2
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, HOLD} state_t;

    state_t state, state_nxt;
    logic wb_fire, rd_fire, wb_skip;
    logic [XLEN-1:0] cap1, cap2;

    // Writeback wins in IDLE, so a same-cycle read is held off until the write lands.
    assign wb_ready  = !reset && (state == IDLE);
    assign req_ready = !reset && (state == IDLE) && !wb_valid;
    assign wb_fire   = wb_valid && wb_ready;
    assign rd_fire   = req_valid && req_ready;

`ifdef REGSEQ_X0_GUARD_EN
    // readReg1/2 still hold the latched source numbers during READ.
    assign wb_skip = (wb_rd == '0);
    assign cap1    = (readReg1 == '0) ? '0 : readData1;
    assign cap2    = (readReg2 == '0) ? '0 : readData2;
`else
    assign wb_skip = 1'b0;
    assign cap1    = readData1;
    assign cap2    = readData2;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wb_fire)      state_nxt = wb_skip ? IDLE : WRITE;
                else if (rd_fire) state_nxt = READ;
            end
            WRITE:   state_nxt = IDLE;
            READ:    state_nxt = HOLD;
            HOLD:    if (op_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            regWrite    <= 1'b0;
            readReg1    <= '0;
            readReg2    <= '0;
            writeReg    <= '0;
            writeData   <= '0;
            op_valid    <= 1'b0;
            op_rs1_data <= '0;
            op_rs2_data <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (wb_fire && !wb_skip) begin
                        regWrite  <= 1'b1;
                        writeReg  <= wb_rd;
                        writeData <= wb_data;
                    end else if (rd_fire) begin
                        readReg1 <= req_rs1;
                        readReg2 <= req_rs2;
                    end
                end
                WRITE: regWrite <= 1'b0;
                READ: begin
                    op_rs1_data <= cap1;
                    op_rs2_data <= cap2;
                    op_valid    <= 1'b1;
                end
                HOLD: if (op_ready) op_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer with a behavioural 32x64 register file.
module tb_regfile_sequencer;
    localparam int XLEN = 64;
    localparam int AW   = 5;
`ifdef REGSEQ_X0_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, req_valid, req_ready, op_valid, op_ready, wb_valid, wb_ready, regWrite;
    logic [AW-1:0] req_rs1, req_rs2, wb_rd, readReg1, readReg2, writeReg;
    logic [XLEN-1:0] op_rs1_data, op_rs2_data, wb_data, writeData, readData1, readData2;

    always #5 clk = ~clk;

    regfile_sequencer #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .op_valid(op_valid), .op_ready(op_ready), .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .regWrite(regWrite), .readReg1(readReg1), .readReg2(readReg2),
        .writeReg(writeReg), .writeData(writeData),
        .readData1(readData1), .readData2(readData2)
    );

    // Register file: writes at posedge, read ports refresh on negedge while not writing.
    logic [XLEN-1:0] rf [32];
    logic rf_clear;
    always @(posedge clk) begin
        if (rf_clear) for (int i = 0; i < 32; i++) rf[i] <= 64'(i);
        else if (regWrite) rf[writeReg] <= writeData;
    end
    always @(negedge clk) begin
        if (!regWrite) begin
            readData1 <= rf[readReg1];
            readData2 <= rf[readReg2];
        end
    end

    int vecs = 0, errs = 0, pops = 0, wpulses = 0, cyc = 0;
    logic [127:0] exp_q [$];
    logic [127:0] e;
    logic in_read = 1'b0;
    logic [XLEN-1:0] shadow [32];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every operand transfer; also checks write/read isolation.
    always @(negedge clk) begin
        if (regWrite) wpulses++;
        if (in_read) chk("no_write_during_read", 64'(regWrite), 64'd0);
        in_read <= req_valid && req_ready && !reset;
        if (op_valid && op_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                vecs++; errs++;
                $display("FAIL unexpected_op: got %h/%h with nothing expected", op_rs1_data, op_rs2_data);
            end else begin
                e = exp_q.pop_front();
                chk("op_rs1", op_rs1_data, e[127:64]);
                chk("op_rs2", op_rs2_data, e[63:0]);
            end
        end
    end

    function automatic logic [63:0] rexp(input logic [4:0] rs);
        return (GUARD && rs == 5'd0) ? 64'd0 : shadow[rs];
    endfunction

    task automatic do_read(input logic [4:0] a, input logic [4:0] b,
                           input logic [63:0] e1, input logic [63:0] e2, input int stall);
        int n, p0;
        logic [63:0] h1, h2;
        req_rs1 = a; req_rs2 = b; req_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        if (!req_ready) begin
            vecs++; errs++;
            $display("FAIL req_accept: req_ready stayed 0, required 1");
            req_valid = 1'b0;
            return;
        end
        p0 = pops;
        exp_q.push_back({e1, e2});
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); chk("read_lat_k1", 64'(op_valid), 64'd0);
        @(negedge clk); chk("read_lat_k2", 64'(op_valid), 64'd1);
        h1 = op_rs1_data; h2 = op_rs2_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(op_valid), 64'd1);
            chk("hold_rs1", op_rs1_data, h1);
            chk("hold_rs2", op_rs2_data, h2);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_wb_ready", 64'(wb_ready), 64'd0);
        end
        @(posedge clk); #1 op_ready = 1'b1;
        n = 0;
        while (pops == p0 && n < 50) begin @(posedge clk); n++; end
        #1 op_ready = 1'b0;
        chk("one_transfer", 64'(pops - p0), 64'd1);
    endtask

    task automatic do_write(input logic [4:0] rd, input logic [63:0] d);
        int n, p0;
        logic skip;
        skip = GUARD && (rd == 5'd0);
        wb_rd = rd; wb_data = d; wb_valid = 1'b1;
        p0 = wpulses;
        n = 0;
        do begin @(negedge clk); n++; end while (!wb_ready && n < 50);
        if (!wb_ready) begin
            vecs++; errs++;
            $display("FAIL wb_accept: wb_ready stayed 0, required 1");
            wb_valid = 1'b0;
            return;
        end
        @(posedge clk); #1 wb_valid = 1'b0;
        if (!skip) shadow[rd] = d;
        @(negedge clk);
        chk("wb_regwrite", 64'(regWrite), 64'(!skip));
        if (!skip) begin
            chk("wb_writereg", 64'(writeReg), 64'(rd));
            chk("wb_writedata", writeData, d);
        end
        @(posedge clk); #1;
        chk("wb_pulse_count", 64'(wpulses - p0), skip ? 64'd0 : 64'd1);
    endtask

    initial begin
        int n, p0;
        int t [2];
        reset = 1'b1; rf_clear = 1'b1;
        req_valid = 0; op_ready = 0; wb_valid = 0;
        req_rs1 = '0; req_rs2 = '0; wb_rd = '0; wb_data = '0;
        for (int i = 0; i < 32; i++) shadow[i] = 64'(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_wb_ready", 64'(wb_ready), 64'd0);
        @(posedge clk); #1 reset = 1'b0; rf_clear = 1'b0;
        @(negedge clk);
        chk("rst_regwrite", 64'(regWrite), 64'd0);
        chk("rst_op_valid", 64'(op_valid), 64'd0);
        chk("rst_readreg1", 64'(readReg1), 64'd0);
        chk("rst_readreg2", 64'(readReg2), 64'd0);
        chk("rst_writereg", 64'(writeReg), 64'd0);
        chk("rst_writedata", writeData, 64'd0);
        chk("rst_op_rs1", op_rs1_data, 64'd0);
        chk("rst_op_rs2", op_rs2_data, 64'd0);
        chk("idle_req_ready", 64'(req_ready), 64'd1);
        chk("idle_wb_ready", 64'(wb_ready), 64'd1);
        @(posedge clk); #1;

        // Basic read of the initial file contents, held two cycles.
        do_read(5'd3, 5'd7, 64'd3, 64'd7, 2);

        // Same-cycle writeback and read of the same register.
        p0 = wpulses;
        wb_rd = 5'd5; wb_data = 64'hDEAD; wb_valid = 1'b1;
        req_rs1 = 5'd5; req_rs2 = 5'd5; req_valid = 1'b1;
        @(negedge clk);
        chk("raw_wb_ready", 64'(wb_ready), 64'd1);
        chk("raw_req_blocked", 64'(req_ready), 64'd0);
        @(posedge clk); #1 wb_valid = 1'b0;
        shadow[5] = 64'hDEAD;
        @(negedge clk);
        chk("raw_regwrite", 64'(regWrite), 64'd1);
        chk("raw_writereg", 64'(writeReg), 64'd5);
        chk("raw_req_in_write", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        do_read(5'd5, 5'd5, 64'hDEAD, 64'hDEAD, 0);
        chk("raw_pulses", 64'(wpulses - p0), 64'd1);

        // Consumer stall of four cycles.
        do_read(5'd10, 5'd31, 64'd10, 64'd31, 4);

        // Back-to-back reads with op_ready tied high.
        op_ready = 1'b1; req_rs1 = 5'd1; req_rs2 = 5'd2; req_valid = 1'b1;
        p0 = pops; n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clk);
            if (req_ready) begin
                t[n] = cyc;
                exp_q.push_back({64'd1, 64'd2});
                n++;
            end
        end
        @(posedge clk); #1 req_valid = 1'b0;
        chk("b2b_accepts", 64'(n), 64'd2);
        if (n == 2) chk("b2b_spacing", 64'(t[1] - t[0]), 64'd3);
        n = 0;
        while (pops - p0 < 2 && n < 20) begin @(posedge clk); n++; end
        #1 op_ready = 1'b0;
        chk("b2b_transfers", 64'(pops - p0), 64'd2);

        // Reset while in READ discards the request.
        p0 = pops;
        req_rs1 = 5'd4; req_rs2 = 5'd6; req_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        @(posedge clk); #1 req_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_op_valid", 64'(op_valid), 64'd0);
        chk("mid_rst_regwrite", 64'(regWrite), 64'd0);
        chk("mid_rst_readreg1", 64'(readReg1), 64'd0);
        chk("mid_rst_op_rs1", op_rs1_data, 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1 reset = 1'b0; op_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_no_op", 64'(op_valid), 64'd0);
        end
        @(posedge clk); #1 op_ready = 1'b0;
        chk("mid_rst_no_pop", 64'(pops - p0), 64'd0);

        // x0 handling.
        do_write(5'd0, 64'h55);
        do_read(5'd0, 5'd0, GUARD ? 64'd0 : 64'h55, GUARD ? 64'd0 : 64'h55, 0);

        // Random mix of reads and writes.
        for (int i = 0; i < 1000; i++) begin
            logic [4:0] a, b;
            a = 5'($urandom_range(0, 31));
            b = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) do_write(a, {32'($urandom), 32'($urandom)});
            else do_read(a, b, rexp(a), rexp(b), int'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
